// File: rtl/aes_block_ctrl_pkg.sv
// Shared types and constants for the AES block sequencer.
package aes_block_ctrl_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, ROUND, STORE} aes_ctrl_state_e;

  localparam int unsigned AES_NR_128        = 10;
  localparam int unsigned AES_NR_192        = 12;
  localparam int unsigned AES_NR_256        = 14;
  localparam int unsigned AES_WORDS_PER_BLK = 4;
  localparam int unsigned AES_WORD_W        = 32;
  localparam int unsigned AES_BLK_W         = AES_WORD_W * AES_WORDS_PER_BLK;

  // Bit offset of word slot 0..3 inside a block; slot 0 is the MSW.
  function automatic logic [6:0] word_lsb(input logic [1:0] slot);
    return {~slot, 5'b0};
  endfunction

endpackage

// File: rtl/aes_word_unpacker.sv
// Holds one 128-bit result and serializes it MSW first over a valid/ready port.
module aes_word_unpacker
  import aes_block_ctrl_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  load_i,
  input  logic [AES_BLK_W-1:0]  data_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [AES_WORD_W-1:0] data_o,
  output logic                  last_o
);

  logic [AES_BLK_W-1:0] obuf_q;
  logic [1:0]           cnt_q;
  logic                 vld_q;
  logic                 hs;

  assign hs      = vld_q && ready_i;
  assign last_o  = hs && (cnt_q == 2'd3);
  assign valid_o = vld_q;
  assign data_o  = obuf_q[AES_BLK_W-1 -: AES_WORD_W];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      obuf_q <= '0;
      cnt_q  <= '0;
      vld_q  <= 1'b0;
    end else if (clear_i) begin
      cnt_q <= '0;
      vld_q <= 1'b0;
    end else if (load_i) begin
      obuf_q <= data_i;
      cnt_q  <= '0;
      vld_q  <= 1'b1;
    end else if (hs) begin
      // Shift so the next word always sits at the output slice.
      obuf_q <= {obuf_q[AES_BLK_W-AES_WORD_W-1:0], {AES_WORD_W{1'b0}}};
      cnt_q  <= cnt_q + 2'd1;
      if (cnt_q == 2'd3) vld_q <= 1'b0;
    end
  end

endmodule

// File: rtl/aes_block_ctrl.sv
// Sequencer for the AES round datapath: packs input words, steps rounds 0..NR, unpacks results.
module aes_block_ctrl
  import aes_block_ctrl_pkg::*;
#(
  parameter int unsigned NR    = AES_NR_128,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             clear_i,
  input  logic [CNT_W-1:0] nb_blocks_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [31:0]      in_data_i,
  output logic             dp_load_o,
  output logic [127:0]     dp_state_o,
  output logic             dp_round_en_o,
  output logic [3:0]       dp_round_idx_o,
  output logic             dp_final_o,
  input  logic             dp_ack_i,
  input  logic [127:0]     dp_state_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [31:0]      out_data_o,
  output logic [3:0]       out_strb_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] blk_cnt_o
);

  localparam logic [3:0] LAST_RND = 4'(NR);

  aes_ctrl_state_e  state_q, state_d;
  logic [1:0]       word_cnt_q;
  logic [3:0]       rnd_q;
  logic [CNT_W-1:0] nb_q, blk_cnt_q, blk_cnt_nxt;
  logic [127:0]     blk_q;
  logic             load_q, done_q, zdone_q;
  logic             start_ok, in_hs, last_word, rnd_step, rnd_done, unpk_last;

  // zdone_q marks the zero-block done cycle, which still counts as busy.
  assign start_ok    = start_i && !clear_i && (state_q == IDLE) && !zdone_q;
  assign in_ready_o  = (state_q == LOAD) && !clear_i;
  assign in_hs       = in_valid_i && in_ready_o;
  assign last_word   = in_hs && (word_cnt_q == 2'd3);
  assign rnd_step    = dp_round_en_o && dp_ack_i && !clear_i;
  assign rnd_done    = rnd_step && (rnd_q == LAST_RND);
  assign blk_cnt_nxt = blk_cnt_q + CNT_W'(1);

  assign dp_round_en_o  = (state_q == ROUND);
  assign dp_round_idx_o = rnd_q;
  assign dp_final_o     = dp_round_en_o && (rnd_q == LAST_RND);
  assign dp_load_o      = load_q;
  assign dp_state_o     = blk_q;
  assign out_strb_o     = 4'hF;
  assign busy_o         = (state_q != IDLE) || zdone_q;
  assign done_o         = done_q;
  assign blk_cnt_o      = blk_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clear_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start_ok && (nb_blocks_i != '0)) state_d = LOAD;
        LOAD:    if (last_word) state_d = ROUND;
        ROUND:   if (rnd_done) state_d = STORE;
        STORE:   if (unpk_last) state_d = (blk_cnt_nxt == nb_q) ? IDLE : LOAD;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      word_cnt_q <= '0;
      rnd_q      <= '0;
      nb_q       <= '0;
      blk_cnt_q  <= '0;
      blk_q      <= '0;
      load_q     <= 1'b0;
      done_q     <= 1'b0;
      zdone_q    <= 1'b0;
    end else begin
      load_q  <= last_word;
      done_q  <= 1'b0;
      zdone_q <= 1'b0;
      if (clear_i) begin
        word_cnt_q <= '0;
        rnd_q      <= '0;
        nb_q       <= '0;
        blk_cnt_q  <= '0;
      end else begin
        if (start_ok) begin
          nb_q       <= nb_blocks_i;
          blk_cnt_q  <= '0;
          word_cnt_q <= '0;
          if (nb_blocks_i == '0) begin
            done_q  <= 1'b1;
            zdone_q <= 1'b1;
          end
        end
        if (in_hs) begin
          blk_q[word_lsb(word_cnt_q) +: 32] <= in_data_i;
          word_cnt_q <= word_cnt_q + 2'd1;
        end
        if (last_word)                          rnd_q <= '0;
        else if (rnd_step && rnd_q != LAST_RND) rnd_q <= rnd_q + 4'd1;
        if ((state_q == STORE) && unpk_last) begin
          blk_cnt_q <= blk_cnt_nxt;
          if (blk_cnt_nxt == nb_q) done_q <= 1'b1;
        end
      end
    end
  end

  aes_word_unpacker u_unpk (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (clear_i),
    .load_i  (rnd_done),
    .data_i  (dp_state_i),
    .valid_o (out_valid_o),
    .ready_i (out_ready_i),
    .data_o  (out_data_o),
    .last_o  (unpk_last)
  );

endmodule
